// File: rtl/riscv_pkg.sv
// Shared definitions for the load/store unit.
//  - LDST_* : access size codes carried on core_size_i
//  - lsu_state_t : LSU controller states
//  - is_misaligned() : natural-alignment test for a size code and addr[1:0]
package riscv_pkg;

    localparam logic [2:0] LDST_B  = 3'd0;
    localparam logic [2:0] LDST_H  = 3'd1;
    localparam logic [2:0] LDST_W  = 3'd2;
    localparam logic [2:0] LDST_BU = 3'd4;
    localparam logic [2:0] LDST_HU = 3'd5;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } lsu_state_t;

    // Byte accesses are never misaligned; unknown size codes go to the bus
    // with be=0 rather than being flagged.
    function automatic logic is_misaligned(input logic [2:0] size,
                                           input logic [1:0] addr_lo);
        logic r;
        r = 1'b0;
        case (size)
            LDST_H, LDST_HU: r = addr_lo[0];
            LDST_W:          r = (addr_lo != 2'b00);
            default:         r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lsu_data_align.sv
// Combinational lane logic for the load/store unit.
//  size    in  3   access size code (LDST_*)
//  addr_lo in  2   byte offset within the word
//  wd      in  32  store data, LSB-aligned
//  rdata   in  32  bus read word
//  be      out 4   byte enables for the access
//  wdata   out 32  store data replicated into every lane
//  rd      out 32  load result, sign- or zero-extended
// Unknown size codes produce be=0, wdata=0 and rd=0.
module lsu_data_align
    import riscv_pkg::*;
(
    input  logic [2:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wd,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] rd
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Half-word lanes are selected by addr[1] only; addr[0] is known to be
    // zero for any half access that reaches the bus.
    assign lane_b = rdata[{addr_lo, 3'b000} +: 8];
    assign lane_h = rdata[{addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        be    = 4'b0000;
        wdata = 32'h0;
        rd    = 32'h0;
        case (size)
            LDST_B, LDST_BU: begin
                be    = 4'b0001 << addr_lo;
                wdata = {4{wd[7:0]}};
                rd    = (size == LDST_B) ? {{24{lane_b[7]}}, lane_b}
                                         : {24'h0, lane_b};
            end
            LDST_H, LDST_HU: begin
                be    = 4'b0011 << {addr_lo[1], 1'b0};
                wdata = {2{wd[15:0]}};
                rd    = (size == LDST_H) ? {{16{lane_h[15]}}, lane_h}
                                         : {16'h0, lane_h};
            end
            LDST_W: begin
                be    = 4'b1111;
                wdata = wd;
                rd    = rdata;
            end
            default: begin
                be    = 4'b0000;
                wdata = 32'h0;
                rd    = 32'h0;
            end
        endcase
    end

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit between the core data port and a 32-bit word bus.
//  clk_i, rst_i           clock, synchronous active-high reset
//  core_req_i/we_i/size_i/addr_i/wd_i   core access request
//  core_rd_o              extended load data, valid in the completion cycle
//  core_stall_o           hold the core this cycle
//  mem_req_o/we_o/be_o/addr_o/wd_o      word bus request (held until ready)
//  mem_rd_i, mem_ready_i  bus read data and completion strobe
//  misaligned_o           pulse: misaligned access dropped without bus traffic
//  bus_err_o              pulse: no ready within MAX_WAIT WAIT cycles
// Handshake: a request is issued in IDLE the same cycle core_req_i is seen and
// held on the bus from the latched copy until the first WAIT cycle with
// mem_ready_i=1; mem_ready_i has no effect in IDLE.
module riscv_lsu
    import riscv_pkg::*;
#(
    parameter int MAX_WAIT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i,
    output logic        misaligned_o,
    output logic        bus_err_o
);

    localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;

    lsu_state_t    state;
    logic [CW-1:0] wait_cnt;
    logic          lat_we;
    logic [2:0]    lat_size;
    logic [31:0]   lat_addr;
    logic [3:0]    lat_be;
    logic [31:0]   lat_wd;

    logic [2:0]    sel_size;
    logic [1:0]    sel_addr_lo;
    logic [3:0]    al_be;
    logic [31:0]   al_wd;
    logic [31:0]   al_rd;
    logic          misaligned;
    logic          timeout;

    assign misaligned = is_misaligned(core_size_i, core_addr_i[1:0]);
    assign timeout    = (MAX_WAIT != 0) && (wait_cnt == CW'(MAX_WAIT));

    // One aligner serves both phases: in IDLE it formats the incoming
    // request, in WAIT it extracts load data using the latched size/offset.
    assign sel_size    = (state == WAIT) ? lat_size      : core_size_i;
    assign sel_addr_lo = (state == WAIT) ? lat_addr[1:0] : core_addr_i[1:0];

    lsu_data_align u_align (
        .size    (sel_size),
        .addr_lo (sel_addr_lo),
        .wd      (core_wd_i),
        .rdata   (mem_rd_i),
        .be      (al_be),
        .wdata   (al_wd),
        .rd      (al_rd)
    );

    always_comb begin
        core_rd_o    = 32'h0;
        core_stall_o = 1'b0;
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        mem_be_o     = 4'b0000;
        mem_addr_o   = 32'h0;
        mem_wd_o     = 32'h0;
        misaligned_o = 1'b0;
        bus_err_o    = 1'b0;
        if (!rst_i) begin
            case (state)
                IDLE: begin
                    if (core_req_i) begin
                        if (misaligned) begin
                            misaligned_o = 1'b1;
                        end else begin
                            mem_req_o    = 1'b1;
                            core_stall_o = 1'b1;
                            mem_we_o     = core_we_i;
                            mem_be_o     = al_be;
                            mem_addr_o   = {core_addr_i[31:2], 2'b00};
                            mem_wd_o     = al_wd;
                        end
                    end
                end
                WAIT: begin
                    mem_req_o  = 1'b1;
                    mem_we_o   = lat_we;
                    mem_be_o   = lat_be;
                    mem_addr_o = {lat_addr[31:2], 2'b00};
                    mem_wd_o   = lat_wd;
                    // A ready arriving in the timeout cycle still completes.
                    if (mem_ready_i) begin
                        core_rd_o = al_rd;
                    end else if (timeout) begin
                        bus_err_o = 1'b1;
                    end else begin
                        core_stall_o = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            wait_cnt <= '0;
            lat_we   <= 1'b0;
            lat_size <= 3'd0;
            lat_addr <= 32'h0;
            lat_be   <= 4'b0000;
            lat_wd   <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    wait_cnt <= '0;
                    if (core_req_i && !misaligned) begin
                        state    <= WAIT;
                        lat_we   <= core_we_i;
                        lat_size <= core_size_i;
                        lat_addr <= core_addr_i;
                        lat_be   <= al_be;
                        lat_wd   <= al_wd;
                    end
                end
                WAIT: begin
                    if (mem_ready_i || timeout) begin
                        state    <= IDLE;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_lsu.sv
// Bench for riscv_lsu: directed scenarios followed by randomized traffic,
// checked against an arithmetic model of the access rules.
module tb_riscv_lsu;
    import riscv_pkg::*;

    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        core_req_i;
    logic        core_we_i;
    logic [2:0]  core_size_i;
    logic [31:0] core_addr_i;
    logic [31:0] core_wd_i;
    logic [31:0] core_rd_o;
    logic        core_stall_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wd_o;
    logic [31:0] mem_rd_i;
    logic        mem_ready_i;
    logic        misaligned_o;
    logic        bus_err_o;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    riscv_lsu #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .core_req_i   (core_req_i),
        .core_we_i    (core_we_i),
        .core_size_i  (core_size_i),
        .core_addr_i  (core_addr_i),
        .core_wd_i    (core_wd_i),
        .core_rd_o    (core_rd_o),
        .core_stall_o (core_stall_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_be_o     (mem_be_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wd_o     (mem_wd_o),
        .mem_rd_i     (mem_rd_i),
        .mem_ready_i  (mem_ready_i),
        .misaligned_o (misaligned_o),
        .bus_err_o    (bus_err_o)
    );

    // {req, stall, we, be, addr, wd, misaligned, bus_err}
    wire [72:0]  bus_obs = {mem_req_o, core_stall_o, mem_we_o, mem_be_o,
                            mem_addr_o, mem_wd_o, misaligned_o, bus_err_o};
    wire [104:0] all_out = {core_rd_o, bus_obs};

    // ---------------- reference model ----------------
    function automatic int unsigned m_width(input logic [2:0] s);
        if (s == LDST_B || s == LDST_BU) return 1;
        if (s == LDST_H || s == LDST_HU) return 2;
        if (s == LDST_W) return 4;
        return 0;
    endfunction

    function automatic logic m_misaligned(input logic [2:0] s, input logic [31:0] a);
        int unsigned w;
        w = m_width(s);
        return (w > 1) && ((a % w) != 0);
    endfunction

    function automatic int unsigned m_off(input logic [2:0] s, input logic [31:0] a);
        int unsigned w;
        w = m_width(s);
        return (a % 4) - ((a % 4) % w);
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] s, input logic [31:0] a);
        int unsigned w;
        w = m_width(s);
        if (w == 0) return 4'b0000;
        return 4'(((1 << w) - 1) << m_off(s, a));
    endfunction

    function automatic logic [31:0] m_wd(input logic [2:0] s, input logic [31:0] d);
        int unsigned w;
        w = m_width(s);
        if (w == 1) return (d % 256) * 32'h0101_0101;
        if (w == 2) return (d % 65536) * 32'h0001_0001;
        if (w == 4) return d;
        return 32'h0;
    endfunction

    function automatic logic [31:0] m_rd(input logic [2:0] s, input logic [31:0] a,
                                         input logic [31:0] r);
        int unsigned w;
        logic [31:0] mask, v;
        w = m_width(s);
        if (w == 0) return 32'h0;
        if (w == 4) return r;
        mask = (32'd1 << (8 * w)) - 1;
        v = (r >> (8 * m_off(s, a))) & mask;
        if ((s == LDST_B || s == LDST_H) && v[8 * w - 1]) v = v | ~mask;
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            core_req_i  = 1'b0;
            core_addr_i = $urandom;
            mem_ready_i = 1'($urandom_range(0, 1));
            mem_rd_i    = $urandom;
            @(negedge clk);
            n_cmp++;
            if ({mem_req_o, core_stall_o, misaligned_o, bus_err_o} !== 4'b0000) begin
                n_err++;
                $display("FAIL idle: req/stall/mis/err=%b required 0000",
                         {mem_req_o, core_stall_o, misaligned_o, bus_err_o});
            end
        end
    endtask

    // One core access; wait_cycles = ready-low WAIT cycles before ready.
    task automatic do_access(input logic we, input logic [2:0] size,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input logic [31:0] rdata, input int wait_cycles,
                             output logic [31:0] got_rd);
        logic [72:0] exp_bus;
        logic [31:0] exp_rd;
        @(posedge clk); #1;
        core_req_i  = 1'b1;
        core_we_i   = we;
        core_size_i = size;
        core_addr_i = addr;
        core_wd_i   = wd;
        mem_ready_i = 1'($urandom_range(0, 1));
        mem_rd_i    = $urandom;
        @(negedge clk);
        got_rd = core_rd_o;
        if (m_misaligned(size, addr)) begin
            n_cmp++;
            if ({mem_req_o, core_stall_o, misaligned_o, bus_err_o, core_rd_o} !==
                {4'b0010, 32'h0}) begin
                n_err++;
                $display("FAIL misaligned size=%0d addr=%h: req/stall/mis/err=%b rd=%h required 0010 rd=0",
                         size, addr, {mem_req_o, core_stall_o, misaligned_o, bus_err_o}, core_rd_o);
            end
            return;
        end
        exp_bus = {1'b1, 1'b1, we, m_be(size, addr), addr & ~32'h3,
                   m_wd(size, wd), 1'b0, 1'b0};
        exp_q.push_back(m_rd(size, addr, rdata));
        n_cmp++;
        if (bus_obs !== exp_bus) begin
            n_err++;
            $display("FAIL req_cycle size=%0d addr=%h: got %h required %h",
                     size, addr, bus_obs, exp_bus);
        end
        for (int i = 0; i < wait_cycles; i++) begin
            @(posedge clk); #1;
            // Core-side inputs are scrambled: the bus must follow the latched copy.
            core_we_i   = 1'($urandom_range(0, 1));
            core_size_i = 3'($urandom_range(0, 7));
            core_addr_i = $urandom;
            core_wd_i   = $urandom;
            mem_ready_i = 1'b0;
            mem_rd_i    = $urandom;
            @(negedge clk);
            n_cmp++;
            if (bus_obs !== exp_bus) begin
                n_err++;
                $display("FAIL wait_cycle %0d size=%0d addr=%h: got %h required %h",
                         i, size, addr, bus_obs, exp_bus);
            end
        end
        @(posedge clk); #1;
        mem_ready_i = 1'b1;
        mem_rd_i    = rdata;
        @(negedge clk);
        exp_bus[71] = 1'b0;
        exp_rd = exp_q.pop_front();
        got_rd = core_rd_o;
        n_cmp++;
        if (bus_obs !== exp_bus) begin
            n_err++;
            $display("FAIL complete_bus size=%0d addr=%h: got %h required %h",
                     size, addr, bus_obs, exp_bus);
        end
        n_cmp++;
        if (core_rd_o !== exp_rd) begin
            n_err++;
            $display("FAIL complete_rd size=%0d addr=%h rdata=%h: got %h required %h",
                     size, addr, rdata, core_rd_o, exp_rd);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        rst_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            core_req_i  = 1'b1;
            core_size_i = LDST_W;
            core_addr_i = $urandom;
            mem_ready_i = 1'b1;
            mem_rd_i    = $urandom;
            @(negedge clk);
            n_cmp++;
            if (all_out !== '0) begin
                n_err++;
                $display("FAIL reset_outputs: got %h required 0", all_out);
            end
        end
        @(posedge clk); #1;
        rst_i = 1'b0;
        core_req_i = 1'b0;
        idle_cycles(2);
    endtask

    task automatic test_lw_basic;
        logic [31:0] rd;
        do_access(1'b0, LDST_W, 32'h104, $urandom, 32'hDEAD_BEEF, 0, rd);
        n_cmp++;
        if (rd !== 32'hDEAD_BEEF) begin
            n_err++;
            $display("FAIL lw_basic: rd=%h required deadbeef", rd);
        end
    endtask

    task automatic test_lb_lbu;
        logic [31:0] rd;
        do_access(1'b0, LDST_B, 32'h103, $urandom, 32'h80FF_0000, 0, rd);
        n_cmp++;
        if (rd !== 32'hFFFF_FF80) begin
            n_err++;
            $display("FAIL lb_sign: rd=%h required ffffff80", rd);
        end
        do_access(1'b0, LDST_BU, 32'h103, $urandom, 32'h80FF_0000, 1, rd);
        n_cmp++;
        if (rd !== 32'h0000_0080) begin
            n_err++;
            $display("FAIL lbu_zero: rd=%h required 00000080", rd);
        end
    endtask

    task automatic test_sh_wait;
        logic [31:0] rd;
        do_access(1'b1, LDST_H, 32'h102, 32'h1234_ABCD, $urandom, 3, rd);
        idle_cycles(1);
    endtask

    task automatic test_misaligned;
        logic [31:0] rd;
        do_access(1'b0, LDST_W, 32'h101, $urandom, $urandom, 0, rd);
        do_access(1'b1, LDST_H, 32'h203, $urandom, $urandom, 0, rd);
        do_access(1'b0, LDST_HU, 32'h305, $urandom, $urandom, 0, rd);
        do_access(1'b0, LDST_W, 32'h402, $urandom, $urandom, 0, rd);
        idle_cycles(1);
    endtask

    task automatic test_timeout;
        @(posedge clk); #1;
        core_req_i  = 1'b1;
        core_we_i   = 1'b0;
        core_size_i = LDST_W;
        core_addr_i = 32'h200;
        mem_ready_i = 1'b0;
        // Request cycle plus MAX_WAIT WAIT cycles stay stalled.
        for (int i = 0; i <= MAX_WAIT; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({mem_req_o, core_stall_o, bus_err_o} !== 3'b110) begin
                n_err++;
                $display("FAIL timeout_stall %0d: req/stall/err=%b required 110",
                         i, {mem_req_o, core_stall_o, bus_err_o});
            end
            @(posedge clk); #1;
            mem_ready_i = 1'b0;
            mem_rd_i    = $urandom;
        end
        @(negedge clk);
        n_cmp++;
        if ({core_stall_o, bus_err_o, core_rd_o} !== {2'b01, 32'h0}) begin
            n_err++;
            $display("FAIL timeout_err: stall/err=%b rd=%h required 01 rd=0",
                     {core_stall_o, bus_err_o}, core_rd_o);
        end
        idle_cycles(2);
    endtask

    task automatic test_reset_mid_wait;
        logic [31:0] rd;
        @(posedge clk); #1;
        core_req_i  = 1'b1;
        core_we_i   = 1'b0;
        core_size_i = LDST_W;
        core_addr_i = 32'h300;
        mem_ready_i = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++;
        if ({mem_req_o, core_stall_o} !== 2'b11) begin
            n_err++;
            $display("FAIL rst_mid_pre: req/stall=%b required 11", {mem_req_o, core_stall_o});
        end
        @(posedge clk); #1;
        rst_i       = 1'b1;
        mem_ready_i = 1'b1;
        mem_rd_i    = $urandom;
        @(negedge clk);
        n_cmp++;
        if (all_out !== '0) begin
            n_err++;
            $display("FAIL rst_mid_outputs: got %h required 0", all_out);
        end
        @(posedge clk); #1;
        rst_i      = 1'b0;
        core_req_i = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({mem_req_o, core_stall_o, bus_err_o} !== 3'b000) begin
            n_err++;
            $display("FAIL rst_mid_idle: req/stall/err=%b required 000",
                     {mem_req_o, core_stall_o, bus_err_o});
        end
        do_access(1'b0, LDST_W, 32'h300, $urandom, 32'hCAFE_F00D, 2, rd);
        idle_cycles(1);
    endtask

    task automatic test_back_to_back;
        logic [31:0] rd;
        do_access(1'b0, LDST_HU, 32'h012, $urandom, 32'h8001_7FFE, 0, rd);
        do_access(1'b1, LDST_B,  32'h021, 32'h0000_005A, $urandom, 0, rd);
        do_access(1'b0, LDST_H,  32'h030, $urandom, 32'h1234_8765, 1, rd);
        do_access(1'b0, LDST_W,  32'h044, $urandom, 32'h0BAD_F00D, MAX_WAIT, rd);
        idle_cycles(1);
    endtask

    task automatic test_random;
        logic [31:0] rd;
        logic [2:0]  size;
        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 9))
                0, 1:    size = LDST_B;
                2:       size = LDST_BU;
                3, 4:    size = LDST_H;
                5:       size = LDST_HU;
                6, 7:    size = LDST_W;
                8:       size = 3'd3;
                default: size = 3'($urandom_range(6, 7));
            endcase
            do_access(1'($urandom_range(0, 1)), size, $urandom, $urandom, $urandom,
                      $urandom_range(0, MAX_WAIT), rd);
            idle_cycles($urandom_range(0, 2));
        end
    endtask

    initial begin
        rst_i       = 1'b1;
        core_req_i  = 1'b0;
        core_we_i   = 1'b0;
        core_size_i = LDST_W;
        core_addr_i = 32'h0;
        core_wd_i   = 32'h0;
        mem_rd_i    = 32'h0;
        mem_ready_i = 1'b0;

        test_reset;
        test_lw_basic;
        test_lb_lbu;
        test_sh_wait;
        test_misaligned;
        test_timeout;
        test_reset_mid_wait;
        test_back_to_back;
        test_random;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
